// File: rtl/ccc_reconfig_pkg.sv
// Shared types and widths for the RTG4 CCC dynamic-reconfiguration APB master.
// Holds the controller state encoding and the response status codes returned to the host.
package ccc_reconfig_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SLVERR  = 2'b01,
    ST_LOCK_TO = 2'b10,
    ST_APB_TO  = 2'b11
  } status_e;

endpackage

// File: rtl/ccc_lock_monitor.sv
// Watches the asynchronous CCC LOCK output after a reconfiguration write: two-flop
// synchroniser, consecutive-high stability counter and an overall timeout counter.
module ccc_lock_monitor
  import ccc_reconfig_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic lock_async,
  output logic lock_ok,
  output logic lock_timeout
);

  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(LOCK_TIMEOUT);

  logic              sync1_q;
  logic              sync2_q;
  logic              active_q, active_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              stab_hit;
  logic              to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      active_q <= 1'b0;
      stab_q   <= '0;
      to_q     <= '0;
    end else begin
      sync1_q  <= lock_async;
      sync2_q  <= sync1_q;
      active_q <= active_d;
      stab_q   <= stab_d;
      to_q     <= to_d;
    end
  end

  // A LOCK drop restarts only the stability count; the timeout keeps running.
  always_comb begin
    stab_d   = stab_q;
    to_d     = to_q;
    active_d = active_q;
    stab_hit = 1'b0;
    to_hit   = 1'b0;
    if (start) begin
      stab_d   = '0;
      to_d     = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!sync2_q) begin
        stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
        stab_d = stab_q + STAB_W'(1);
      end
      if (to_q != TO_MAX) begin
        to_d = to_q + TO_W'(1);
      end
      stab_hit = (stab_d == STAB_MAX);
      to_hit   = (to_d == TO_MAX);
      if (stab_hit || to_hit) begin
        active_d = 1'b0;
      end
    end
  end

  // Lock achieved in the same cycle as the timeout counts as success.
  assign lock_ok      = stab_hit;
  assign lock_timeout = to_hit & ~stab_hit;

endmodule

// File: rtl/ccc_apb_reconfig_master.sv
// APB3 initiator driving the CCC APB_S_* reconfiguration port: one host command per
// transfer, optional wait for LOCK after the last write, and a held response to the host.
module ccc_apb_reconfig_master
  import ccc_reconfig_pkg::*;
#(
  parameter int APB_TIMEOUT  = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 16
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic              CMD_LAST,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic [1:0]        RSP_STATUS,
  input  logic              CCC_BUSY,
  input  logic              CCC_LOCK,
  output logic              APB_M_PSEL,
  output logic              APB_M_PENABLE,
  output logic              APB_M_PWRITE,
  output logic [ADDR_W-1:0] APB_M_PADDR,
  output logic [DATA_W-1:0] APB_M_PWDATA,
  input  logic [DATA_W-1:0] APB_M_PRDATA,
  input  logic              APB_M_PREADY,
  input  logic              APB_M_PSLVERR
);

  localparam int WAIT_W = $clog2(APB_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(APB_TIMEOUT);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic                wr_q, wr_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                rdy_en_q;
  logic                cmd_ready;
  logic                lock_start;
  logic                lock_ok;
  logic                lock_timeout;

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      wr_q     <= 1'b0;
      last_q   <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      wait_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      wr_q     <= wr_d;
      last_q   <= last_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
      rdy_en_q <= 1'b1;
    end
  end

  // rdy_en_q keeps CMD_READY low while reset is held even though IDLE is combinational.
  assign cmd_ready = (state_q == S_IDLE) & ~CCC_BUSY & rdy_en_q;

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    wr_d       = wr_q;
    last_d     = last_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rdata_d    = rdata_q;
    wait_d     = wait_q;
    lock_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID && cmd_ready) begin
          wr_d     = CMD_WRITE;
          last_d   = CMD_LAST;
          paddr_d  = CMD_ADDR;
          pwdata_d = CMD_WDATA;
          rdata_d  = '0;
          status_d = ST_OK;
          wait_d   = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (APB_M_PREADY) begin
          if (!wr_q) begin
            rdata_d = APB_M_PRDATA;
          end
          if (APB_M_PSLVERR) begin
            status_d = ST_SLVERR;
            state_d  = S_RESP;
          end else if (wr_q && last_q) begin
            lock_start = 1'b1;
            state_d    = S_WAIT_LOCK;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
          end
          if (wait_d == WAIT_MAX) begin
            status_d = ST_APB_TO;
            state_d  = S_RESP;
          end
        end
      end
      S_WAIT_LOCK: begin
        if (lock_ok) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (lock_timeout) begin
          status_d = ST_LOCK_TO;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  ccc_lock_monitor #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_mon (
    .clk         (PCLK),
    .rst_n       (PRESET_N),
    .start       (lock_start),
    .lock_async  (CCC_LOCK),
    .lock_ok     (lock_ok),
    .lock_timeout(lock_timeout)
  );

  // PSEL/PENABLE decode straight from state so an async reset drops them at once.
  assign CMD_READY     = cmd_ready;
  assign APB_M_PSEL    = (state_q == S_SETUP) | (state_q == S_ACCESS);
  assign APB_M_PENABLE = (state_q == S_ACCESS);
  assign APB_M_PWRITE  = wr_q;
  assign APB_M_PADDR   = paddr_q;
  assign APB_M_PWDATA  = pwdata_q;
  assign RSP_VALID     = (state_q == S_RESP);
  assign RSP_RDATA     = rdata_q;
  assign RSP_STATUS    = status_q;

endmodule

// File: tb/tb_ccc_apb_reconfig_master.sv
// Directed and randomized transactions against a cycle-count reference model of the
// APB reconfiguration master, including lock wait, timeouts, SLVERR, BUSY and reset.
module tb_ccc_apb_reconfig_master;

  localparam int APB_TO  = 255;
  localparam int LOCK_TO = 1000;
  localparam int LOCK_ST = 16;

  logic       PCLK = 1'b0;
  logic       PRESET_N;
  logic       CMD_VALID, CMD_READY, CMD_WRITE, CMD_LAST;
  logic [5:0] CMD_ADDR;
  logic [7:0] CMD_WDATA;
  logic       RSP_VALID, RSP_READY;
  logic [7:0] RSP_RDATA;
  logic [1:0] RSP_STATUS;
  logic       CCC_BUSY, CCC_LOCK;
  logic       APB_M_PSEL, APB_M_PENABLE, APB_M_PWRITE;
  logic [5:0] APB_M_PADDR;
  logic [7:0] APB_M_PWDATA, APB_M_PRDATA;
  logic       APB_M_PREADY, APB_M_PSLVERR;

  int n_assert = 0;
  int n_fail   = 0;
  bit lock_sched[$];

  ccc_apb_reconfig_master #(
    .APB_TIMEOUT (APB_TO),
    .LOCK_TIMEOUT(LOCK_TO),
    .LOCK_STABLE (LOCK_ST)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE), .CMD_LAST(CMD_LAST),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_STATUS(RSP_STATUS),
    .CCC_BUSY(CCC_BUSY), .CCC_LOCK(CCC_LOCK),
    .APB_M_PSEL(APB_M_PSEL), .APB_M_PENABLE(APB_M_PENABLE), .APB_M_PWRITE(APB_M_PWRITE),
    .APB_M_PADDR(APB_M_PADDR), .APB_M_PWDATA(APB_M_PWDATA), .APB_M_PRDATA(APB_M_PRDATA),
    .APB_M_PREADY(APB_M_PREADY), .APB_M_PSLVERR(APB_M_PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Raw LOCK level sampled at the j-th edge after the WAIT_LOCK entry edge.
  function automatic bit sched_val(input int j);
    if (j < 1) return 1'b0;
    if (j - 1 < lock_sched.size()) return lock_sched[j-1];
    if (lock_sched.size() == 0) return 1'b0;
    return lock_sched[lock_sched.size()-1];
  endfunction

  // Cycles from accept (accept cycle counted as 1) until RSP_VALID, plus status.
  function automatic void model(input bit wr, input bit last, input int d, input bit slverr,
                                output int lat, output logic [1:0] st);
    int run;
    bit s;
    if (d < 0) begin
      lat = 2 + APB_TO;
      st  = 2'b11;
    end else if (slverr) begin
      lat = 3 + d;
      st  = 2'b01;
    end else if (!(wr && last)) begin
      lat = 3 + d;
      st  = 2'b00;
    end else begin
      run = 0;
      lat = 3 + d + LOCK_TO;
      st  = 2'b10;
      for (int m = 1; m <= LOCK_TO; m++) begin
        s   = sched_val(m - 2);
        run = s ? run + 1 : 0;
        if (run == LOCK_ST) begin
          lat = 3 + d + m;
          st  = 2'b00;
          break;
        end
      end
    end
  endfunction

  task automatic run_cmd(input string tag, input bit wr, input bit last, input logic [5:0] addr,
                         input logic [7:0] wdata, input int d, input logic [7:0] prdata,
                         input bit slverr, input int busy_cycles, input int rsp_hold);
    int lat, exp_lat, psel_n, pen_n, t, wait_n;
    logic [1:0] exp_st;
    logic [7:0] exp_rd;
    bit stable_ok, hold_ok, apb_idle_ok, lock_path;
    model(wr, last, d, slverr, exp_lat, exp_st);
    exp_rd    = (!wr && d >= 0) ? prdata : 8'h00;
    lock_path = wr && last && !slverr && d >= 0;
    CCC_LOCK  = 1'b0;
    CMD_WRITE = wr; CMD_LAST = last; CMD_ADDR = addr; CMD_WDATA = wdata; CMD_VALID = 1'b1;
    CCC_BUSY  = (busy_cycles > 0);
    for (int b = 0; b < busy_cycles; b++) begin
      #1;
      check({tag, "_busy_ready"}, 32'(CMD_READY), 32'd0);
      tick();
    end
    CCC_BUSY = 1'b0;
    wait_n = 0;
    #1;
    while (!CMD_READY && wait_n < 20) begin
      tick();
      wait_n++;
    end
    check({tag, "_cmd_ready"}, 32'(CMD_READY), 32'd1);
    tick();
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'($urandom); CMD_LAST = 1'($urandom);
    CMD_ADDR = 6'($urandom); CMD_WDATA = 8'($urandom);
    lat = 1; psel_n = 0; pen_n = 0; stable_ok = 1'b1;
    while (!RSP_VALID && lat < 3000) begin
      t = lat + 1;
      APB_M_PREADY  = (d >= 0) && (t == 3 + d);
      APB_M_PRDATA  = APB_M_PREADY ? prdata : 8'($urandom);
      APB_M_PSLVERR = APB_M_PREADY ? slverr : 1'($urandom);
      CCC_LOCK      = lock_path ? sched_val(t - (3 + d)) : 1'b0;
      if (APB_M_PSEL) psel_n++;
      if (APB_M_PENABLE) pen_n++;
      if (APB_M_PSEL && (APB_M_PADDR !== addr || APB_M_PWRITE !== wr || (wr && APB_M_PWDATA !== wdata)))
        stable_ok = 1'b0;
      tick();
      lat++;
    end
    APB_M_PREADY = 1'b0; APB_M_PSLVERR = 1'b0;
    apb_idle_ok = !APB_M_PSEL && !APB_M_PENABLE;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_status"}, 32'(RSP_STATUS), 32'(exp_st));
    check({tag, "_rdata"}, 32'(RSP_RDATA), 32'(exp_rd));
    check({tag, "_psel_cycles"}, 32'(psel_n), 32'((d < 0) ? 1 + APB_TO : 2 + d));
    check({tag, "_penable_cycles"}, 32'(pen_n), 32'((d < 0) ? APB_TO : 1 + d));
    check({tag, "_apb_stable"}, 32'(stable_ok), 32'd1);
    check({tag, "_apb_idle_at_rsp"}, 32'(apb_idle_ok), 32'd1);
    hold_ok = 1'b1;
    RSP_READY = 1'b0;
    for (int h = 0; h < rsp_hold; h++) begin
      tick();
      if (RSP_VALID !== 1'b1 || RSP_STATUS !== exp_st || RSP_RDATA !== exp_rd) hold_ok = 1'b0;
    end
    check({tag, "_rsp_hold"}, 32'(hold_ok), 32'd1);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    check({tag, "_rsp_cleared"}, 32'(RSP_VALID), 32'd0);
    check({tag, "_ready_after"}, 32'(CMD_READY), 32'd1);
    $display("txn %s: wr=%0b last=%0b addr=0x%02h lat=%0d status=%0d rdata=0x%02h",
             tag, wr, last, addr, lat, RSP_STATUS, RSP_RDATA);
  endtask

  task automatic random_sched();
    int len;
    bit v;
    lock_sched.delete();
    v = 1'b0;
    while (lock_sched.size() < 150) begin
      len = int'($urandom_range(1, 20));
      for (int k = 0; k < len; k++) lock_sched.push_back(v);
      v = ~v;
    end
    lock_sched.push_back(1'b1);
  endtask

  initial begin
    int rd, rs, wait_n;
    PRESET_N = 1'b0;
    CMD_VALID = 0; CMD_WRITE = 0; CMD_LAST = 0; CMD_ADDR = 0; CMD_WDATA = 0;
    RSP_READY = 0; CCC_BUSY = 0; CCC_LOCK = 0;
    APB_M_PRDATA = 0; APB_M_PREADY = 0; APB_M_PSLVERR = 0;
    #23;
    check("reset_outputs",
          {13'd0, CMD_READY, APB_M_PSEL, APB_M_PENABLE, APB_M_PWRITE, APB_M_PADDR, APB_M_PWDATA,
           RSP_VALID, RSP_RDATA, RSP_STATUS}, 32'd0);
    #7 PRESET_N = 1'b1;
    tick(); tick(); tick();

    run_cmd("wr_basic", 1, 0, 6'h05, 8'hA3, 0, 8'h00, 0, 0, 0);
    run_cmd("rd_wait4", 0, 0, 6'h3F, 8'h00, 4, 8'h5C, 0, 0, 2);

    lock_sched.delete();
    for (int k = 0; k < 100; k++) lock_sched.push_back(1'b0);
    for (int k = 0; k < 5; k++) lock_sched.push_back(1'b1);
    for (int k = 0; k < 10; k++) lock_sched.push_back(1'b0);
    for (int k = 0; k < 20; k++) lock_sched.push_back(1'b1);
    run_cmd("wr_last_lock", 1, 1, 6'h11, 8'h7E, 0, 8'h00, 0, 0, 1);

    lock_sched.delete();
    run_cmd("lock_timeout", 1, 1, 6'h12, 8'h01, 1, 8'h00, 0, 0, 0);
    run_cmd("apb_timeout", 0, 0, 6'h20, 8'h00, -1, 8'h00, 0, 0, 0);
    run_cmd("slverr_last", 1, 1, 6'h13, 8'hC4, 1, 8'h00, 1, 0, 0);
    run_cmd("busy_read", 0, 0, 6'h0A, 8'h00, 0, 8'h96, 0, 5, 0);

    // Reset in the middle of an ACCESS phase, then a normal read.
    CMD_WRITE = 0; CMD_LAST = 0; CMD_ADDR = 6'h2A; CMD_VALID = 1; APB_M_PREADY = 0;
    wait_n = 0;
    #1;
    while (!CMD_READY && wait_n < 20) begin
      tick();
      wait_n++;
    end
    tick();
    CMD_VALID = 0;
    tick(); tick();
    check("rst_mid_penable_before", 32'(APB_M_PENABLE), 32'd1);
    #2 PRESET_N = 1'b0;
    #1;
    check("rst_mid_outputs", {29'd0, APB_M_PSEL, APB_M_PENABLE, RSP_VALID}, 32'd0);
    tick(); tick();
    #2 PRESET_N = 1'b1;
    tick(); tick();
    run_cmd("rd_after_reset", 0, 0, 6'h2B, 8'h00, 2, 8'h3D, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      rd = int'($urandom_range(0, 6));
      rs = int'($urandom_range(0, 2));
      run_cmd($sformatf("rand_%0d", i), 1'($urandom), 1'b0, 6'($urandom), 8'($urandom),
              rd, 8'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)), rs);
    end
    for (int i = 0; i < 3; i++) begin
      random_sched();
      run_cmd($sformatf("rand_lock_%0d", i), 1'b1, 1'b1, 6'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), 8'h00, 1'b0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
